// File: rtl/pool2d_stream.sv
// Streaming 2D pooling (max or average) over raster-order pixels.
// One POOLxPOOL window per W/POOL line-buffer slot. Each slot holds one
// accumulator per channel. A window result is registered one cycle after
// the beat that completes the window.

// Per-channel combine: load, running signed max or running signed sum
module pool2d_lane #(
  parameter int DW = 8,
  parameter int AW = 10,
  parameter int SH = 2
) (
  input  logic          mode,
  input  logic          first,
  input  logic [DW-1:0] px,
  input  logic [AW-1:0] acc,
  output logic [AW-1:0] acc_nxt,
  output logic [DW-1:0] res
);
  logic signed [AW-1:0] px_ext, acc_s, sum, mx, shf;

  // fold one pixel channel into the window accumulator and form the result
  always_comb begin
    px_ext  = {{(AW-DW){px[DW-1]}}, px};
    acc_s   = acc;
    sum     = acc_s + px_ext;
    mx      = (acc_s > px_ext) ? acc_s : px_ext;
    acc_nxt = first ? px_ext : (mode ? sum : mx);
    shf     = $signed(acc_nxt) >>> SH;
    res     = mode ? shf[DW-1:0] : acc_nxt[DW-1:0];
  end
endmodule

module pool2d_stream #(
  parameter int H          = 24,
  parameter int W          = 24,
  parameter int C          = 6,
  parameter int DATA_WIDTH = 8,
  parameter int POOL       = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_mode,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [C*DATA_WIDTH-1:0] i_data,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [C*DATA_WIDTH-1:0] o_data,
  output logic                    o_last
);
  localparam int LP = (POOL == 4) ? 2 : 1;
  localparam int AW = DATA_WIDTH + 2 * LP;
  localparam int NS = W / POOL;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                           state_q, state_d;
  logic [CW-1:0]                    col_q, col_d;
  logic [RW-1:0]                    row_q, row_d;
  logic                             mode_q, mode_d;
  logic                             o_valid_q, o_valid_d;
  logic                             o_last_q, o_last_d;
  logic [C*DATA_WIDTH-1:0]          o_data_q, o_data_d;
  logic [NS-1:0][C-1:0][AW-1:0]     lb_q, lb_d;

  logic                             accept, first, complete, col_end, row_end, mode_eff;
  logic [SW-1:0]                    slot;
  logic [C-1:0][AW-1:0]             acc_cur, acc_nxt;
  logic [C-1:0][DATA_WIDTH-1:0]     res;

  assign i_ready  = !o_valid_q || o_ready;
  assign accept   = i_valid && i_ready;
  assign col_end  = (col_q == CW'(W - 1));
  assign row_end  = (row_q == RW'(H - 1));
  assign slot     = SW'(col_q >> LP);
  assign first    = (row_q[LP-1:0] == '0) && (col_q[LP-1:0] == '0);
  assign complete = (&row_q[LP-1:0]) && (&col_q[LP-1:0]);
  // the frame's first pixel is always a load, so mode only matters once latched
  assign mode_eff = (state_q == IDLE) ? i_mode : mode_q;
  assign acc_cur  = lb_q[slot];

  assign o_valid  = o_valid_q;
  assign o_data   = o_data_q;
  assign o_last   = o_last_q;

  for (genvar k = 0; k < C; k++) begin : g_lane
    pool2d_lane #(.DW(DATA_WIDTH), .AW(AW), .SH(2 * LP)) u_lane (
      .mode    (mode_eff),
      .first   (first),
      .px      (i_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .acc     (acc_cur[k]),
      .acc_nxt (acc_nxt[k]),
      .res     (res[k])
    );
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: leave IDLE on the first beat, return after the last pixel
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (accept && row_end && col_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: latch the pooling mode on the frame's first beat
  always_comb begin
    mode_d = mode_q;
    if (state_q == IDLE && accept) mode_d = i_mode;
  end

  // datapath next state: position counters, line buffer, output register
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    lb_d      = lb_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_last_d  = o_last_q;
    if (accept) begin
      lb_d[slot] = acc_nxt;
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    if (accept && complete) begin
      o_valid_d = 1'b1;
      o_data_d  = res;
      o_last_d  = row_end && col_end;
    end else if (o_valid_q && o_ready) begin
      o_valid_d = 1'b0;
    end
  end

  // control and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q     <= '0;
      row_q     <= '0;
      mode_q    <= 1'b0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_last_q  <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      mode_q    <= mode_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_last_q  <= o_last_d;
    end
  end

  // line buffer: every slot is overwritten by the first row of each window row
  always_ff @(posedge clk) begin
    lb_q <= lb_d;
  end
endmodule

// File: tb/tb_pool2d_stream.sv
// Bench for pool2d_stream: directed and randomized frames against a
// window-level arithmetic reference model.
module tb_pool2d_stream;
  localparam int H = 4, W = 4, C = 2, DW = 8, P = 2;
  localparam int NPIX = H * W;
  localparam int OW = C * DW;

  logic          clk, reset, i_mode, i_valid, i_ready, o_valid, o_ready, o_last;
  logic [OW-1:0] i_data, o_data;

  pool2d_stream #(.H(H), .W(W), .C(C), .DATA_WIDTH(DW), .POOL(P)) dut (
    .clk(clk), .reset(reset), .i_mode(i_mode), .i_valid(i_valid), .i_ready(i_ready),
    .i_data(i_data), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [OW:0] obs_q[$];
  logic [OW:0] exp_q[$];
  int          pix[NPIX][C];
  int          checks = 0;
  int          failures = 0;
  int          obs_base = 0;
  bit          rnd_rdy = 0;

  // capture every output handshake as {last, data}
  always @(negedge clk) if (o_valid && o_ready) obs_q.push_back({o_last, o_data});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) o_ready = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [OW-1:0] pix_word(input int idx);
    logic [OW-1:0] w;
    int v;
    w = '0;
    for (int ch = 0; ch < C; ch++) begin
      v = pix[idx][ch];
      w[ch*DW +: DW] = v[DW-1:0];
    end
    return w;
  endfunction

  function automatic int floor_div(input int s, input int d);
    int q;
    q = s / d;
    if ((s % d) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  // reference: pooled windows in raster order, last flag on the final window
  task automatic add_expected(input bit mode);
    logic [OW-1:0] w;
    int m, s, v, e;
    for (int wr = 0; wr < H / P; wr++)
      for (int wc = 0; wc < W / P; wc++) begin
        w = '0;
        for (int ch = 0; ch < C; ch++) begin
          m = -100000;
          s = 0;
          for (int dy = 0; dy < P; dy++)
            for (int dx = 0; dx < P; dx++) begin
              v = pix[(wr * P + dy) * W + wc * P + dx][ch];
              s += v;
              if (v > m) m = v;
            end
          e = mode ? floor_div(s, P * P) : m;
          w[ch*DW +: DW] = e[DW-1:0];
        end
        exp_q.push_back({(wr == H / P - 1) && (wc == W / P - 1), w});
      end
  endtask

  task automatic gen_ramp();
    for (int i = 0; i < NPIX; i++) begin
      pix[i][0] = i;
      pix[i][1] = -i;
    end
  endtask

  task automatic gen_random();
    for (int i = 0; i < NPIX; i++)
      for (int ch = 0; ch < C; ch++) pix[i][ch] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic drive_beat(input logic [OW-1:0] d, input logic m, input bit gap);
    bit acc;
    acc = 0;
    if (gap && $urandom_range(0, 3) == 0) begin
      i_valid = 1'b0;
      tick();
    end
    i_valid = 1'b1;
    i_data  = d;
    i_mode  = m;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = i_ready;
      tick();
    end
    if (!acc) check("accept_timeout", 0, 1);
    i_valid = 1'b0;
  endtask

  // drive a frame; optionally check one-cycle latency against exp_q from index k0
  task automatic drive_frame(input bit mode, input int toggle_at, input bit gap,
                             input bit lat, input int k0);
    int k;
    logic [OW:0] e;
    bit cmpl;
    k = k0;
    for (int i = 0; i < NPIX; i++) begin
      drive_beat(pix_word(i), (toggle_at >= 0 && i >= toggle_at) ? ~mode : mode, gap);
      if (lat) begin
        cmpl = ((i / W) % P == P - 1) && ((i % W) % P == P - 1);
        check("lat_valid", 32'(o_valid), 32'(cmpl));
        if (cmpl) begin
          e = exp_q[k];
          check("lat_data", 32'(o_data), 32'(e[OW-1:0]));
          check("lat_last", 32'(o_last), 32'(e[OW]));
          k++;
        end
      end
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && (obs_q.size() - obs_base) < exp_q.size(); n++) tick();
    rnd_rdy = 0;
    o_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic cmp(input string tag);
    logic [OW:0] o, e;
    int n;
    n = obs_q.size() - obs_base;
    check({tag, "_count"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      o = obs_q[obs_base + i];
      e = exp_q[i];
      check(tag, 32'(o), 32'(e));
    end
    obs_base = obs_q.size();
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; i_mode = 1'b0; i_valid = 1'b0; i_data = '0; o_ready = 1'b1;
    repeat (3) tick();
    check("rst_o_valid", 32'(o_valid), 0);
    check("rst_o_last", 32'(o_last), 0);
    check("rst_o_data", 32'(o_data), 0);
    check("rst_i_ready", 32'(i_ready), 1);
    reset = 1'b0;
    tick();

    // max mode, ready held high, one-cycle latency
    gen_ramp();
    add_expected(1'b0);
    check("max_ref0", 32'(exp_q[0]), 32'h0_0005);
    drive_frame(1'b0, -1, 0, 1, 0);
    drain();
    cmp("max");

    // average mode on the same frame, floor on negatives
    add_expected(1'b1);
    check("avg_ref0", 32'(exp_q[0]), 32'h0_FD02);
    drive_frame(1'b1, -1, 0, 1, 0);
    drain();
    cmp("avg");

    // backpressure on the first output with input held valid
    add_expected(1'b0);
    o_ready = 1'b0;
    for (int i = 0; i < 6; i++) drive_beat(pix_word(i), 1'b0, 0);
    check("bp_i_ready", 32'(i_ready), 0);
    i_valid = 1'b1;
    i_data  = pix_word(6);
    for (int n = 0; n < 4; n++) begin
      tick();
      check("bp_o_valid", 32'(o_valid), 1);
      check("bp_o_data", 32'(o_data), 32'h0005);
      check("bp_o_last", 32'(o_last), 0);
      check("bp_i_ready_hold", 32'(i_ready), 0);
    end
    o_ready = 1'b1;
    for (int i = 6; i < NPIX; i++) drive_beat(pix_word(i), 1'b0, 0);
    drain();
    cmp("bp");

    // mode toggled mid-frame is ignored; the next frame picks it up
    add_expected(1'b0);
    drive_frame(1'b0, 5, 0, 0, 0);
    add_expected(1'b1);
    drive_frame(1'b1, -1, 0, 0, 0);
    drain();
    cmp("mode_chg");

    // reset mid-frame abandons the frame; clean frame afterwards
    for (int i = 0; i < 10; i++) drive_beat(pix_word(i), 1'b0, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_o_valid", 32'(o_valid), 0);
    check("mid_rst_o_data", 32'(o_data), 0);
    check("mid_rst_o_last", 32'(o_last), 0);
    tick();
    reset = 1'b0;
    tick();
    obs_base = obs_q.size();
    add_expected(1'b0);
    drive_frame(1'b0, -1, 0, 1, 0);
    drain();
    cmp("post_rst");

    // back-to-back random frames with random output backpressure
    for (int rep = 0; rep < 3; rep++) begin
      bit m0, m1;
      m0 = 1'($urandom_range(0, 1));
      m1 = 1'($urandom_range(0, 1));
      rnd_rdy = 1;
      gen_random();
      add_expected(m0);
      drive_frame(m0, -1, rep[0], 0, 0);
      gen_random();
      add_expected(m1);
      drive_frame(m1, -1, 0, 0, 0);
      drain();
      check("b2b_last4", 32'(exp_q[3][OW]), 1);
      cmp("b2b");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pool2d_stream.md
POOL2D_STREAM -- requirements
Module: pool2d_stream

Interface
REQ-001 SHALL have parameter H, default 24, input frame height in pixels.
REQ-002 SHALL have parameter W, default 24, input frame width in pixels.
REQ-003 SHALL have parameter C, default 6, channels packed per pixel beat.
REQ-004 SHALL have parameter DATA_WIDTH, default 8, signed two's-complement bits per channel.
REQ-005 SHALL have parameter POOL, default 2, window size and stride; legal values are 2 or 4; H and W are multiples of POOL.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port i_mode, input, 1, pooling mode: 0 = max, 1 = average.
REQ-009 SHALL have port i_valid, input, 1, input beat valid.
REQ-010 SHALL have port i_ready, output, 1, block accepts the input beat.
REQ-011 SHALL have port i_data, input, C*DATA_WIDTH, one pixel in raster order; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port o_valid, output, 1, pooled pixel valid.
REQ-013 SHALL have port o_ready, input, 1, downstream accepts the output.
REQ-014 SHALL have port o_data, output, C*DATA_WIDTH, pooled pixel using the same channel packing.
REQ-015 SHALL have port o_last, output, 1, marks the final pooled pixel of a frame, qualified by o_valid.

Function
REQ-016 SHALL accept an input beat when i_valid and i_ready are both high in the same cycle, and SHALL ignore i_data in any other cycle.
REQ-017 SHALL drive i_ready = !o_valid || o_ready, combinationally.
REQ-018 SHALL track input position with column counter col (0..W-1) and row counter row (0..H-1): col increments per accepted beat; on wrap, col returns to 0 and row increments; row wraps to 0 after the last pixel.
REQ-019 SHALL have FSM states IDLE (no pixel of the current frame accepted) and RUN; IDLE->RUN on an accepted beat, which latches i_mode; RUN->IDLE on accepting pixel (H-1, W-1).
REQ-020 SHALL ignore i_mode changes while in RUN; the latched mode applies to the whole frame.
REQ-021 SHALL hold a line buffer of W/POOL slots; each slot holds C accumulators of DATA_WIDTH+2*log2(POOL) bits, signed.
REQ-022 SHALL map an accepted pixel to slot col/POOL; when row%POOL==0 and col%POOL==0, the slot SHALL load the sign-extended pixel, and otherwise it SHALL combine it per channel (max mode: signed maximum; average mode: signed sum).
REQ-023 SHALL complete a window on the pixel with row%POOL==POOL-1 and col%POOL==POOL-1, and SHALL register the result into o_data with o_valid=1 at the next rising edge (latency 1 cycle).
REQ-024 SHALL output in average mode the full-window sum arithmetically shifted right by 2*log2(POOL), which floors toward negative infinity, truncated to DATA_WIDTH; in max mode it SHALL output the maximum unchanged.
REQ-025 SHALL emit outputs in raster order over (H/POOL) x (W/POOL), and SHALL set o_last=1 only with the output produced by input pixel (H-1, W-1).
REQ-026 SHALL hold o_valid, o_data and o_last stable while o_valid=1 and o_ready=0.
REQ-027 SHALL clear o_valid on o_valid && o_ready unless a new window completes in the same cycle, in which case it SHALL load the new result with no bubble.
REQ-028 SHALL start the next frame on the beat after the last pixel of the previous frame, with no idle cycle required.

Reset
REQ-029 SHALL, on reset assertion at any time, force o_valid=0, o_last=0, o_data=0, col=0, row=0, FSM=IDLE and latched mode=0 asynchronously.
REQ-030 SHALL discard line-buffer contents on reset, which need not clear them, because the first window row overwrites each slot; a frame interrupted by reset is abandoned and produces no output.

Verification (H=W=4, C=2, DATA_WIDTH=8, POOL=2; ch0=r*4+c, ch1=-(r*4+c))
REQ-031 SHALL verify max mode with o_ready held at 1 -> outputs (ch0,ch1) = (5,0), (7,-2), (13,-8), (15,-10), o_last only on the 4th, each 1 cycle after the completing beat.
REQ-032 SHALL verify average mode on the same frame -> (2,-3), (4,-5), (10,-11), (12,-13), confirming floor rounding on negative values.
REQ-033 SHALL verify backpressure: o_ready=0 after the first output, with i_valid held high -> i_ready drops the cycle after the completing beat, o_data stays (5,0), and the first output's o_data, o_valid and o_last stay stable while o_ready=0, with no output lost or duplicated after o_ready=1.
REQ-034 SHALL verify a mode change mid-frame: i_mode toggled 0->1 at pixel (1,1) -> the whole frame stays max; the next frame is average.
REQ-035 SHALL verify reset mid-frame: reset pulsed after pixel (2,1), then a clean frame -> o_valid=0 immediately, no stale output, and the clean frame reproduces the REQ-031 values.
REQ-036 SHALL verify back-to-back frames with o_ready toggled randomly -> 8 outputs in order, o_last on outputs 4 and 8 only.
